// File: rtl/field_swapper_pipe.sv
// field_swapper_pipe: permutes a DATA_W-bit word as NUM_F fields of FIELD_W
// bits (pass, pairwise swap, reverse, rotate-left) and queues the result in a
// DEPTH-entry output FIFO with valid/ready handshakes on both sides.
//
// Optional feature macro: SWAP_STATS_EN
//   When defined, adds output swap_count[15:0], a saturating count of output
//   handshakes whose word was produced by a mode other than pass.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both 1. in_ready = !full and out_valid = !empty are
// decoded purely from registered pointers, so neither depends combinationally
// on in_valid or out_ready. A full FIFO never passes a word straight through,
// even when out_ready=1; in_ready rises the cycle after the pop.
module field_swapper_pipe #(
   parameter int DATA_W  = 32,
   parameter int FIELD_W = 4,
   parameter int DEPTH   = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [DATA_W-1:0]                   data_in,
   input  logic [1:0]                          mode,
   input  logic [$clog2(DATA_W/FIELD_W):0]     rot,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [DATA_W-1:0]                   data_out
`ifdef SWAP_STATS_EN
   ,
   output logic [15:0]                         swap_count
`endif
);

   localparam int NUM_F = DATA_W / FIELD_W;
   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_SWAP = 2'b01;
   localparam logic [1:0] MODE_REV  = 2'b10;

   logic [DATA_W-1:0] perm_w;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic              full_w, empty_w;
   logic              push_w, pop_w;

   // Field permutation of the incoming word; mode and rot matter only in the accept cycle.
   always_comb begin
      int r;
      int src;
      perm_w = '0;
      src    = 0;
      r      = int'(rot) % NUM_F;
      for (int i = 0; i < NUM_F; i++) begin
         case (mode)
            MODE_PASS: src = i;
            // Pairs (2k, 2k+1) exchange; an unpaired top field stays put.
            MODE_SWAP: src = ((i ^ 1) < NUM_F) ? (i ^ 1) : i;
            MODE_REV:  src = NUM_F - 1 - i;
            default:   src = (i - r + NUM_F) % NUM_F;
         endcase
         perm_w[i*FIELD_W +: FIELD_W] = data_in[src*FIELD_W +: FIELD_W];
      end
   end

   // Occupancy flags and handshake qualification from the pointer registers.
   always_comb begin
      empty_w   = (wr_ptr_q == rd_ptr_q);
      full_w    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      in_ready  = !full_w;
      out_valid = !empty_w;
      push_w    = in_valid && !full_w;
      pop_w     = out_ready && !empty_w;
      wr_ptr_d  = wr_ptr_q + PTR_W'(push_w);
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop_w);
      data_out  = mem_q[rd_ptr_q[AW-1:0]];
   end

   // Pointer and storage registers; reset discards every queued word and zeroes the head.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (push_w) begin
            mem_q[wr_ptr_q[AW-1:0]] <= perm_w;
         end
      end
   end

`ifdef SWAP_STATS_EN
   logic [1:0]  mode_q [DEPTH];
   logic [15:0] cnt_q, cnt_d;

   // Saturating count of popped words that were not plain pass-through.
   always_comb begin
      cnt_d = cnt_q;
      if (pop_w && (mode_q[rd_ptr_q[AW-1:0]] != MODE_PASS) && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
      swap_count = cnt_q;
   end

   // Per-entry mode storage travels alongside the data so the count is taken at pop time.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mode_q[i] <= MODE_PASS;
         end
      end else begin
         cnt_q <= cnt_d;
         if (push_w) begin
            mode_q[wr_ptr_q[AW-1:0]] <= mode;
         end
      end
   end
`endif

endmodule

// File: tb/tb_field_swapper_pipe.sv
// Self-checking bench for field_swapper_pipe: table vectors, hand-written
// full/reset sequences, randomized traffic against a field-array reference
// model and an expected-word queue. Build with +define+SWAP_STATS_EN to also
// check the swap counter.
module tb_field_swapper_pipe;

   localparam int DEPTH = 2;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // main instance: DATA_W=32, FIELD_W=4
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] data_in, data_out;
   logic [1:0]  mode;
   logic [3:0]  rot;
   logic [15:0] swap_count;

   // byte instance: DATA_W=32, FIELD_W=8
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0] b_data_in, b_data_out;
   logic [1:0]  b_mode;
   logic [2:0]  b_rot;
   logic [15:0] b_swap_count;

   // nibble instance: DATA_W=8, FIELD_W=4
   logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
   logic [7:0]  n_data_in, n_data_out;
   logic [1:0]  n_mode;
   logic [1:0]  n_rot;
   logic [15:0] n_swap_count;

   field_swapper_pipe #(.DATA_W(32), .FIELD_W(4), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
      .mode(mode), .rot(rot),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
`ifdef SWAP_STATS_EN
      , .swap_count(swap_count)
`endif
   );

   field_swapper_pipe #(.DATA_W(32), .FIELD_W(8), .DEPTH(DEPTH)) u_b8 (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in),
      .mode(b_mode), .rot(b_rot),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_data_out)
`ifdef SWAP_STATS_EN
      , .swap_count(b_swap_count)
`endif
   );

   field_swapper_pipe #(.DATA_W(8), .FIELD_W(4), .DEPTH(DEPTH)) u_n8 (
      .clk(clk), .rst(rst),
      .in_valid(n_in_valid), .in_ready(n_in_ready), .data_in(n_data_in),
      .mode(n_mode), .rot(n_rot),
      .out_valid(n_out_valid), .out_ready(n_out_ready), .data_out(n_data_out)
`ifdef SWAP_STATS_EN
      , .swap_count(n_swap_count)
`endif
   );

   // ---------------- scoreboard state ----------------
   logic [31:0] exp_q[$];
   logic [1:0]  exp_m_q[$];
   logic [15:0] model_cnt;
   int          n_tests;
   int          n_fail;
   int          dut_pops;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference permutation: split into a field array, pick by rule, reassemble.
   function automatic logic [31:0] ref_perm(input logic [31:0] w, input int dw, input int fw,
                                            input logic [1:0] m, input int r_in);
      int          nf;
      int          f[32];
      int          src;
      int          r;
      logic [31:0] res;
      nf  = dw / fw;
      r   = r_in % nf;
      res = '0;
      for (int i = 0; i < nf; i++) f[i] = int'((w >> (i * fw)) & ((32'd1 << fw) - 32'd1));
      for (int i = 0; i < nf; i++) begin
         case (m)
            2'd0: src = i;
            2'd1: if (i % 2 == 0) src = (i + 1 < nf) ? i + 1 : i; else src = i - 1;
            2'd2: src = nf - 1 - i;
            default: src = ((i - r) % nf + nf) % nf;
         endcase
         res = res | (32'(f[src]) << (i * fw));
      end
      return res;
   endfunction

   // One clock for the main instance: check flags and head against the model
   // using the values that will be sampled at the coming edge, then advance.
   task automatic tick();
      int sz;
      if (!rst) begin
         exp_q.delete();
         exp_m_q.delete();
         model_cnt = '0;
      end else begin
         sz = exp_q.size();
         check("out_valid", 32'(out_valid), 32'(sz != 0));
         check("in_ready", 32'(in_ready), 32'(sz < DEPTH));
`ifdef SWAP_STATS_EN
         check("swap_count", 32'(swap_count), 32'(model_cnt));
`endif
         if (out_valid && out_ready) dut_pops++;
         if (sz != 0 && out_ready) begin
            logic [1:0] m;
            check("data_out", data_out, exp_q.pop_front());
            m = exp_m_q.pop_front();
            if (m != 2'd0 && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
         end
         if (sz < DEPTH && in_valid) begin
            exp_q.push_back(ref_perm(data_in, 32, 4, mode, int'(rot)));
            exp_m_q.push_back(mode);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic b8_word(input string name, input logic [1:0] m, input logic [2:0] r,
                          input logic [31:0] d, input logic [31:0] exp);
      b_mode = m; b_rot = r; b_data_in = d; b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      check({name, "_valid"}, 32'(b_out_valid), 32'd1);
      check(name, b_data_out, exp);
      tick();
   endtask

   task automatic n8_word(input string name, input logic [1:0] m, input logic [1:0] r,
                          input logic [7:0] d, input logic [7:0] exp);
      n_mode = m; n_rot = r; n_data_in = d; n_in_valid = 1'b1;
      tick();
      n_in_valid = 1'b0;
      check({name, "_valid"}, 32'(n_out_valid), 32'd1);
      check(name, 32'(n_data_out), 32'(exp));
      tick();
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [3:0]  rot;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int pops0;
      bit accepted;
      n_tests = 0; n_fail = 0; dut_pops = 0; model_cnt = '0;
      vecs[0] = '{2'b00, 4'd0,  32'h12345678, 32'h12345678};
      vecs[1] = '{2'b01, 4'd0,  32'h12345678, 32'h21436587};
      vecs[2] = '{2'b10, 4'd0,  32'h12345678, 32'h87654321};
      vecs[3] = '{2'b11, 4'd1,  32'h12345678, 32'h23456781};
      vecs[4] = '{2'b11, 4'd9,  32'h12345678, 32'h23456781};
      vecs[5] = '{2'b11, 4'd0,  32'h12345678, 32'h12345678};
      vecs[6] = '{2'b11, 4'd8,  32'h12345678, 32'h12345678};
      vecs[7] = '{2'b11, 4'd4,  32'h12345678, 32'h56781234};
      vecs[8] = '{2'b11, 4'd15, 32'h12345678, 32'h81234567};
      vecs[9] = '{2'b01, 4'd5,  32'hDEADBEEF, 32'hEDDAEBFE};

      rst = 1'b0;
      in_valid = 0; out_ready = 0; data_in = '0; mode = '0; rot = '0;
      b_in_valid = 0; b_out_ready = 1; b_data_in = '0; b_mode = '0; b_rot = '0;
      n_in_valid = 0; n_out_ready = 1; n_data_in = '0; n_mode = '0; n_rot = '0;
      repeat (3) @(posedge clk);
      #1;

      // reset state
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_data_out", data_out, 32'd0);
      check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
      check("rst_n_out_valid", 32'(n_out_valid), 32'd0);
      check("rst_n_data_out", 32'(n_data_out), 32'd0);
`ifdef SWAP_STATS_EN
      check("rst_swap_count", 32'(swap_count), 32'd0);
`endif
      rst = 1'b1;

      // table vectors, one word at a time with latency check
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         mode = vecs[i].mode; rot = vecs[i].rot; data_in = vecs[i].data; in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         check("vec_latency_valid", 32'(out_valid), 32'd1);
         check("vec_data", data_out, vecs[i].exp);
         tick();
      end

      // other geometries
      n8_word("n8_swap_ab", 2'b01, 2'd0, 8'hAB, 8'hBA);
      n8_word("n8_rev_ab", 2'b10, 2'd0, 8'hAB, 8'hBA);
      n8_word("n8_rot2_ab", 2'b11, 2'd2, 8'hAB, 8'hAB);
      b8_word("b8_rev", 2'b10, 3'd0, 32'h11223344, 32'h44332211);
      b8_word("b8_pass", 2'b00, 3'd0, 32'h11223344, 32'h11223344);
      b8_word("b8_swap", 2'b01, 3'd0, 32'h11223344, 32'h22114433);
      b8_word("b8_rot1", 2'b11, 3'd1, 32'h11223344, 32'h22334411);
      b8_word("b8_rot6", 2'b11, 3'd6, 32'hCAFEF00D, ref_perm(32'hCAFEF00D, 32, 8, 2'b11, 6));

      // full FIFO: A, B accepted, C held until a pop frees a slot
      pops0 = dut_pops;
      out_ready = 1'b0; mode = 2'b00; rot = '0;
      data_in = 32'hA; in_valid = 1'b1; tick();
      data_in = 32'hB; tick();
      data_in = 32'hC;
      check("full_in_ready", 32'(in_ready), 32'd0);
      tick(); tick();
      check("full_held_in_ready", 32'(in_ready), 32'd0);
      check("full_head", data_out, 32'hA);
      out_ready = 1'b1;
      tick();
      check("in_ready_after_pop", 32'(in_ready), 32'd1);
      accepted = 1'b0;
      for (int k = 0; k < 8 && !accepted; k++) begin
         accepted = in_ready;
         tick();
      end
      if (!accepted) check("c_accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      for (int k = 0; k < 8 && out_valid; k++) tick();
      check("full_drained", 32'(out_valid), 32'd0);
      check("full_pop_count", 32'(dut_pops - pops0), 32'd3);

      // continuous stream of 16 words
      pops0 = dut_pops;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         data_in = $urandom; mode = 2'($urandom_range(0, 3)); rot = 4'($urandom_range(0, 15));
         check("stream_in_ready", 32'(in_ready), 32'd1);
         if (k > 0) check("stream_out_valid", 32'(out_valid), 32'd1);
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      check("stream_pop_count", 32'(dut_pops - pops0), 32'd16);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         data_in   = $urandom;
         mode      = 2'($urandom_range(0, 3));
         rot       = 4'($urandom_range(0, 15));
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) tick();

      // reset mid-stream with two words queued
      out_ready = 1'b0; in_valid = 1'b1; mode = 2'b01;
      data_in = 32'h01020304; tick();
      data_in = 32'h05060708; tick();
      check("pre_rst_full", 32'(in_ready), 32'd0);
      rst = 1'b0; out_ready = 1'b1; data_in = 32'h99999999;
      tick();
      rst = 1'b1; in_valid = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_data_out", data_out, 32'd0);
`ifdef SWAP_STATS_EN
      check("midrst_swap_count", 32'(swap_count), 32'd0);
`endif
      tick();
      data_in = 32'h89ABCDEF; mode = 2'b10; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("post_rst_data", data_out, 32'hFEDCBA98);
      tick(); tick();

`ifdef SWAP_STATS_EN
      // counter saturation
      in_valid = 1'b1; out_ready = 1'b1; mode = 2'b01;
      for (int k = 0; k < 65540; k++) begin
         data_in = 32'(k);
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      check("swap_count_sat", 32'(swap_count), 32'h0000FFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
